// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared types for the branch sequencer: PC width, branch-type encodings as
// presented by decode, sequencer states, and two small helper functions.
// ----------------------------------------------------------------------------
package branch_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        BR_BNE  = 2'b00,
        BR_BEQ  = 2'b01,
        BR_JMP  = 2'b10,
        BR_RSVD = 2'b11   // never taken
    } br_type_t;

    typedef enum logic [1:0] {
        S_FETCH,
        S_RESOLVE,
        S_REDIRECT
    } state_t;

    // Conditional-branch decision from the compare flag (nEq = operands differ).
    function automatic logic resolve_taken(input br_type_t t, input logic neq);
        return ((t == BR_BNE) && neq) || ((t == BR_BEQ) && !neq);
    endfunction

    // Saturating 16-bit increment for the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// ----------------------------------------------------------------------------
// branch_target_adder
// PC-relative target: br_pc + sign-extended OFF_W-bit word offset, wrapping
// modulo 2^PC_W. Purely combinational.
//   br_pc  in  PC_W   PC of the branch instruction
//   br_off in  OFF_W  signed word offset
//   tgt    out PC_W   branch target
// ----------------------------------------------------------------------------
module branch_target_adder
    import branch_pkg::*;
#(
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  br_pc,
    input  logic [OFF_W-1:0] br_off,
    output logic [PC_W-1:0]  tgt
);

    logic [PC_W-1:0] off_sext;

    assign off_sext = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    // Carry out of the top bit is dropped, giving the mod 2^16 wrap.
    assign tgt      = br_pc + off_sext;

endmodule

// File: rtl/branch_sequencer.sv
// ----------------------------------------------------------------------------
// branch_sequencer
// Owns the fetch PC. Accepts one branch op at a time from decode, waits for
// the compare result (nEq) and, when the branch is taken (or on JMP), loads
// the target and pulses flush/br_taken for one cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall               freezes sequential PC increment (FETCH/RESOLVE)
//   br_valid/br_ready   branch-op handshake from decode
//   br_type             00 BNE, 01 BEQ, 10 JMP, 11 reserved (not taken)
//   br_pc, br_off       PC-relative target inputs
//   jmp_tgt             absolute JMP target
//   cmp_valid, nEq      compare result, only looked at while resolving
//   pc                  current fetch address
//   flush, br_taken     one-cycle redirect pulses
//
// Optional feature (macro BRANCH_STATS_EN): adds saturating counters
//   stat_taken  - every redirect, JMP included
//   stat_ntaken - every not-taken resolve
// ----------------------------------------------------------------------------
module branch_sequencer
    import branch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int              OFF_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_type,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [OFF_W-1:0] br_off,
    input  logic [PC_W-1:0]  jmp_tgt,
    input  logic             cmp_valid,
    input  logic             nEq,
    output logic [PC_W-1:0]  pc,
    output logic             flush,
    output logic             br_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      stat_taken,
    output logic [15:0]      stat_ntaken
`endif
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    br_type_t        type_q, type_d;
    logic            redirect_q, redirect_d;
    logic            ntaken_evt;
    logic            accept;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] tgt_sum;

    branch_target_adder #(.OFF_W(OFF_W)) u_tgt_adder (
        .br_pc  (br_pc),
        .br_off (br_off),
        .tgt    (tgt_sum)
    );

    assign br_ready = (state_q == S_FETCH) && !rst;
    assign accept   = br_valid && br_ready;
    assign pc_inc   = pc_q + 16'd1;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        type_d     = type_q;
        redirect_d = 1'b0;
        ntaken_evt = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (accept && (br_type_t'(br_type) == BR_JMP)) begin
                    // JMP redirects immediately; the fall-through increment is suppressed.
                    pc_d       = jmp_tgt;
                    redirect_d = 1'b1;
                    state_d    = S_REDIRECT;
                end else begin
                    // Speculative fetch continues on the accept edge too.
                    if (!stall) pc_d = pc_inc;
                    if (accept) begin
                        type_d  = br_type_t'(br_type);
                        tgt_d   = tgt_sum;
                        state_d = S_RESOLVE;
                    end
                end
            end

            S_RESOLVE: begin
                if (cmp_valid && resolve_taken(type_q, nEq)) begin
                    pc_d       = tgt_q;
                    redirect_d = 1'b1;
                    state_d    = S_REDIRECT;
                end else begin
                    if (!stall) pc_d = pc_inc;
                    if (cmp_valid) begin
                        ntaken_evt = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end

            // PC holds for the flush cycle regardless of stall.
            S_REDIRECT: state_d = S_FETCH;

            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            type_q     <= BR_BNE;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            type_q     <= type_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc       = pc_q;
    assign flush    = redirect_q;
    assign br_taken = redirect_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_taken_q, stat_taken_d;
    logic [15:0] stat_ntaken_q, stat_ntaken_d;

    always_comb begin
        stat_taken_d  = redirect_d ? sat_inc(stat_taken_q)  : stat_taken_q;
        stat_ntaken_d = ntaken_evt ? sat_inc(stat_ntaken_q) : stat_ntaken_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_taken_q  <= '0;
            stat_ntaken_q <= '0;
        end else begin
            stat_taken_q  <= stat_taken_d;
            stat_ntaken_q <= stat_ntaken_d;
        end
    end

    assign stat_taken  = stat_taken_q;
    assign stat_ntaken = stat_ntaken_q;
`else
    // Not-taken event only feeds the optional counters.
    logic unused_ntaken;
    assign unused_ntaken = ntaken_evt;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_branch_sequencer
// Directed scenarios followed by random traffic. A behavioural model, stepped
// at every rising edge, pushes the expected per-cycle outputs and every
// expected redirect target into queues; an independent monitor pops and
// compares after each edge.
// ----------------------------------------------------------------------------
module tb_branch_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [1:0]  br_type = 2'b00;
    logic [15:0] br_pc = '0;
    logic [7:0]  br_off = '0;
    logic [15:0] jmp_tgt = '0;
    logic        cmp_valid = 1'b0;
    logic        nEq = 1'b0;
    logic [15:0] pc;
    logic        flush;
    logic        br_taken;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_taken;
    logic [15:0] stat_ntaken;
`endif

    always #5 clk = ~clk;

    branch_sequencer #(.RESET_PC(RESET_PC), .OFF_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_type   (br_type),
        .br_pc     (br_pc),
        .br_off    (br_off),
        .jmp_tgt   (jmp_tgt),
        .cmp_valid (cmp_valid),
        .nEq       (nEq),
        .pc        (pc),
        .flush     (flush),
        .br_taken  (br_taken)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken  (stat_taken),
        .stat_ntaken (stat_ntaken)
`endif
    );

    typedef struct {
        logic [15:0] pc;
        logic        flush;
        logic        ready;
    } exp_t;

    exp_t        cyc_q[$];
    logic [15:0] redir_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An outstanding branch is either absent, waiting for its compare, or
    // the redirect is currently being shown; PC arithmetic is plain integers.
    int m_pc = 0;
    bit m_waiting = 0;
    bit m_redirect = 0;
    int m_kind = 0;
    int m_tgt = 0;
    int m_stat_t = 0;
    int m_stat_n = 0;

    task automatic model_edge();
        int off;
        bit taken;
        if (rst) begin
            m_pc = int'(RESET_PC); m_waiting = 0; m_redirect = 0;
            m_stat_t = 0; m_stat_n = 0;
        end else if (m_redirect) begin
            m_redirect = 0;
        end else if (m_waiting) begin
            if (cmp_valid) begin
                taken = (m_kind == 0 && nEq) || (m_kind == 1 && !nEq);
                m_waiting = 0;
                if (taken) begin
                    m_pc = m_tgt; m_redirect = 1;
                    redir_q.push_back(16'(m_pc));
                    if (m_stat_t < 65535) m_stat_t++;
                end else begin
                    if (m_stat_n < 65535) m_stat_n++;
                    if (!stall) m_pc = (m_pc + 1) % 65536;
                end
            end else if (!stall) begin
                m_pc = (m_pc + 1) % 65536;
            end
        end else if (br_valid && br_type == 2'b10) begin
            m_pc = int'(jmp_tgt); m_redirect = 1;
            redir_q.push_back(16'(m_pc));
            if (m_stat_t < 65535) m_stat_t++;
        end else begin
            if (br_valid) begin
                off = (int'(br_off) >= 128) ? int'(br_off) - 256 : int'(br_off);
                m_tgt = (int'(br_pc) + off + 65536) % 65536;
                m_kind = int'(br_type);
                m_waiting = 1;
            end
            if (!stall) m_pc = (m_pc + 1) % 65536;
        end
    endtask

    // One clock of stimulus: drive on the falling edge, step model on the rising edge.
    task automatic step(input logic r, input logic s, input logic v, input logic [1:0] t,
                        input logic [15:0] bpc, input logic [7:0] off, input logic [15:0] jt,
                        input logic cv, input logic ne);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; br_valid = v; br_type = t; br_pc = bpc;
        br_off = off; jmp_tgt = jt; cmp_valid = cv; nEq = ne;
        @(posedge clk);
        model_edge();
        e.pc    = 16'(m_pc);
        e.flush = m_redirect;
        e.ready = !m_waiting && !m_redirect && !r;
        cyc_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("mon_pc",       pc,             e.pc);
                check("mon_flush",    16'(flush),     16'(e.flush));
                check("mon_br_taken", 16'(br_taken),  16'(e.flush));
                check("mon_br_ready", 16'(br_ready),  16'(e.ready));
            end
            if (flush === 1'b1) begin
                if (redir_q.size() == 0) check("flush_without_redirect", 16'(flush), 16'h0);
                else                     check("redirect_target", pc, redir_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1: reset held two cycles, then free-running increment
        step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'b10, 16'h0, 8'h0, 16'h5555, 1'b0, 1'b0);
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_flush", 16'(flush), 16'h0);
        check("rst_br_ready", 16'(br_ready), 16'h0);
        idle(); #1; check("inc_pc_1", pc, 16'h0001);
        idle(); #1; check("inc_pc_2", pc, 16'h0002);

        // 2: BNE taken, target 0010 - 4 = 000C
        step(1'b0, 1'b0, 1'b1, 2'b00, 16'h0010, 8'hFC, 16'h0, 1'b0, 1'b0);
        #1; check("bne_accept_pc", pc, 16'h0003);
        check("bne_busy_ready", 16'(br_ready), 16'h0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b1, 1'b1);
        #1; check("bne_taken_pc", pc, 16'h000C);
        check("bne_taken_flush", 16'(flush), 16'h1);
        check("bne_taken_br_taken", 16'(br_taken), 16'h1);
        idle(); #1; check("bne_hold_pc", pc, 16'h000C);
        check("bne_flush_one_cycle", 16'(flush), 16'h0);
        idle(); #1; check("bne_resume_pc", pc, 16'h000D);

        // 3: BNE not taken
        step(1'b0, 1'b0, 1'b1, 2'b00, 16'h0010, 8'hFC, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b1, 1'b0);
        #1; check("bne_nt_pc", pc, 16'h000F);
        check("bne_nt_flush", 16'(flush), 16'h0);
        check("bne_nt_ready", 16'(br_ready), 16'h1);

        // 4: BEQ taken with wrap: FFFE + 5 = 0003
        step(1'b0, 1'b0, 1'b1, 2'b01, 16'hFFFE, 8'h05, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b1, 1'b0);
        #1; check("beq_wrap_pc", pc, 16'h0003);
        check("beq_wrap_flush", 16'(flush), 16'h1);
        idle();

        // 5: JMP under stall; cmp_valid pulses are ignored
        step(1'b0, 1'b1, 1'b1, 2'b10, 16'h0, 8'h0, 16'h1234, 1'b1, 1'b1);
        #1; check("jmp_pc", pc, 16'h1234);
        check("jmp_flush", 16'(flush), 16'h1);
        step(1'b0, 1'b1, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b1, 1'b1);
        #1; check("jmp_stall_hold_pc", pc, 16'h1234);
        check("jmp_flush_clear", 16'(flush), 16'h0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b1, 1'b1);
        #1; check("jmp_resume_pc", pc, 16'h1235);
        check("jmp_cmp_ignored", 16'(flush), 16'h0);

        // 6: reset while resolving drops the branch
        step(1'b0, 1'b0, 1'b1, 2'b00, 16'h0100, 8'h10, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        #1; check("mid_rst_pc", pc, RESET_PC);
        check("mid_rst_flush", 16'(flush), 16'h0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 8'h0, 16'h0, 1'b1, 1'b1);
        #1; check("post_rst_no_redirect", 16'(flush), 16'h0);
        check("post_rst_pc", pc, 16'h0001);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                 2'($urandom), 16'($urandom), 8'($urandom), 16'($urandom),
                 ($urandom % 3) == 0, 1'($urandom));
        end
        idle(); idle(); idle();

        @(negedge clk);
        check("cycle_queue_drained", 16'(cyc_q.size()), 16'h0);
        check("all_redirects_seen", 16'(redir_q.size()), 16'h0);
`ifdef BRANCH_STATS_EN
        check("stat_taken", stat_taken, 16'(m_stat_t));
        check("stat_ntaken", stat_ntaken, 16'(m_stat_n));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
